// File: rtl/jelly_stream_crossbar_return_rr.sv
// Round-robin selector for one output port of the return crossbar.
// It searches the request vector starting just after the last winner
// (ptr) and wraps modulo M_NUM, so the last winner has lowest priority.
//   req   : one request bit per responder input
//   ptr   : index of the previous winner
//   found : at least one request is set
//   index : selected input (zero when nothing is found)
module jelly_stream_crossbar_return_rr #(
    parameter int M_NUM     = 4,
    parameter int M_ID_BITS = 2
) (
    input  logic [M_NUM-1:0]     req,
    input  logic [M_ID_BITS-1:0] ptr,
    output logic                 found,
    output logic [M_ID_BITS-1:0] index
);

    int cand_s;

    // first set request after ptr, with wrap-around
    always_comb begin
        found  = 1'b0;
        index  = {M_ID_BITS{1'b0}};
        cand_s = 0;
        for (int k = 1; k <= M_NUM; k++) begin
            cand_s = (int'(ptr) + k) % M_NUM;
            if (!found && req[cand_s]) begin
                found = 1'b1;
                index = M_ID_BITS'(cand_s);
            end else begin
                found = found;
                index = index;
            end
        end
    end

endmodule

// File: rtl/jelly_stream_crossbar_return.sv
// Return-path crossbar: routes response packets from M_NUM responder
// streams to S_NUM requester streams.  Each output has its own
// round-robin arbiter that locks onto a source until its last beat, and
// a one-stage output register.  Delivered beats are tagged with the
// responder index they came from.
//   clk, reset_n, cke             : clock, async active-low reset, clock enable
//   s_id_to/s_last/s_data/s_valid : per-input beat with destination index
//   s_ready                       : per-input accept (combinational)
//   m_id_from/m_last/m_data/m_valid : per-output registered beat
//   m_ready                       : per-output downstream ready
module jelly_stream_crossbar_return #(
    parameter  int M_NUM      = 4,
    parameter  int M_ID_WIDTH = 2,
    parameter  int S_NUM      = 8,
    parameter  int S_ID_WIDTH = 3,
    parameter  int DATA_WIDTH = 32,
    localparam int M_ID_BITS  = (M_ID_WIDTH > 0) ? M_ID_WIDTH : 1,
    localparam int S_ID_BITS  = (S_ID_WIDTH > 0) ? S_ID_WIDTH : 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        cke,
    input  logic [M_NUM*S_ID_BITS-1:0]  s_id_to,
    input  logic [M_NUM-1:0]            s_last,
    input  logic [M_NUM*DATA_WIDTH-1:0] s_data,
    input  logic [M_NUM-1:0]            s_valid,
    output logic [M_NUM-1:0]            s_ready,
    output logic [S_NUM*M_ID_BITS-1:0]  m_id_from,
    output logic [S_NUM-1:0]            m_last,
    output logic [S_NUM*DATA_WIDTH-1:0] m_data,
    output logic [S_NUM-1:0]            m_valid,
    input  logic [S_NUM-1:0]            m_ready
);

    logic [S_NUM-1:0]      busy_r;
    logic [M_ID_BITS-1:0]  grant_r [S_NUM];
    logic [M_ID_BITS-1:0]  ptr_r   [S_NUM];
    logic [S_NUM-1:0]      valid_r;
    logic [S_NUM-1:0]      last_r;
    logic [DATA_WIDTH-1:0] data_r  [S_NUM];
    logic [M_ID_BITS-1:0]  id_r    [S_NUM];

    logic [M_NUM-1:0]      locked_s;
    logic [31:0]           dest_s     [M_NUM];
    logic [M_NUM-1:0]      req_s      [S_NUM];
    logic [S_NUM-1:0]      found_s;
    logic [M_ID_BITS-1:0]  win_s      [S_NUM];
    logic [S_NUM-1:0]      load_s;
    logic [S_NUM-1:0]      acc_s;
    logic [S_NUM-1:0]      acc_last_s;
    logic [M_ID_BITS-1:0]  src_s      [S_NUM];
    logic [DATA_WIDTH-1:0] acc_data_s [S_NUM];
    logic [M_NUM-1:0]      ready_s;

    // widen destinations and find inputs already owned by a busy output
    always_comb begin
        locked_s = {M_NUM{1'b0}};
        for (int i = 0; i < M_NUM; i++) begin
            dest_s[i] = 32'(s_id_to[i*S_ID_BITS +: S_ID_BITS]);
        end
        for (int j = 0; j < S_NUM; j++) begin
            for (int i = 0; i < M_NUM; i++) begin
                locked_s[i] = locked_s[i] | (busy_r[j] & (grant_r[j] == M_ID_BITS'(i)));
            end
        end
    end

    // locked inputs may not open a second packet on another output
    always_comb begin
        for (int j = 0; j < S_NUM; j++) begin
            for (int i = 0; i < M_NUM; i++) begin
                req_s[j][i] = s_valid[i] & (dest_s[i] == 32'(j)) & ~locked_s[i];
            end
        end
    end

    generate
        for (genvar j = 0; j < S_NUM; j++) begin : g_rr
            jelly_stream_crossbar_return_rr #(
                .M_NUM     (M_NUM),
                .M_ID_BITS (M_ID_BITS)
            ) u_rr (
                .req   (req_s[j]),
                .ptr   (ptr_r[j]),
                .found (found_s[j]),
                .index (win_s[j])
            );
        end
    endgenerate

    // per-output source: the locked grant when busy, else the arbiter winner
    always_comb begin
        for (int j = 0; j < S_NUM; j++) begin
            load_s[j]     = cke & (~valid_r[j] | m_ready[j]);
            src_s[j]      = busy_r[j] ? grant_r[j] : win_s[j];
            acc_s[j]      = busy_r[j] ? s_valid[src_s[j]] : found_s[j];
            acc_last_s[j] = s_last[src_s[j]];
            acc_data_s[j] = s_data[int'(src_s[j])*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // ready fan-in; out-of-range destinations are swallowed here
    always_comb begin
        for (int i = 0; i < M_NUM; i++) begin
            ready_s[i] = cke & ~locked_s[i] & (dest_s[i] >= 32'(S_NUM));
            for (int j = 0; j < S_NUM; j++) begin
                ready_s[i] = ready_s[i] | (load_s[j] &
                    ((busy_r[j] & (grant_r[j] == M_ID_BITS'(i))) |
                     (~busy_r[j] & found_s[j] & (win_s[j] == M_ID_BITS'(i)))));
            end
        end
    end

    assign s_ready = ready_s;

    // locks, pointers and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_r  <= {S_NUM{1'b0}};
            valid_r <= {S_NUM{1'b0}};
            last_r  <= {S_NUM{1'b0}};
            for (int j = 0; j < S_NUM; j++) begin
                grant_r[j] <= {M_ID_BITS{1'b0}};
                ptr_r[j]   <= M_ID_BITS'(M_NUM - 1);
                data_r[j]  <= {DATA_WIDTH{1'b0}};
                id_r[j]    <= {M_ID_BITS{1'b0}};
            end
        end else begin
            for (int j = 0; j < S_NUM; j++) begin
                if (load_s[j]) begin
                    if (acc_s[j]) begin
                        valid_r[j] <= 1'b1;
                        last_r[j]  <= acc_last_s[j];
                        data_r[j]  <= acc_data_s[j];
                        id_r[j]    <= src_s[j];
                        busy_r[j]  <= ~acc_last_s[j];
                        if (!busy_r[j]) begin
                            grant_r[j] <= win_s[j];
                            ptr_r[j]   <= win_s[j];
                        end
                    end else begin
                        valid_r[j] <= 1'b0;
                    end
                end
            end
        end
    end

    // flatten registered outputs onto the port buses
    always_comb begin
        m_valid = valid_r;
        m_last  = last_r;
        for (int j = 0; j < S_NUM; j++) begin
            m_data[j*DATA_WIDTH +: DATA_WIDTH] = data_r[j];
            m_id_from[j*M_ID_BITS +: M_ID_BITS] = id_r[j];
        end
    end

endmodule

// File: tb/tb_jelly_stream_crossbar_return.sv
// Bench for the return crossbar: directed scenarios followed by random
// traffic, all checked cycle by cycle against a behavioural model of the
// per-output lock / round-robin rules, plus fixed expectations for the
// directed scenarios.
module tb_jelly_stream_crossbar_return;

    localparam int M_NUM      = 4;
    localparam int M_ID_WIDTH = 2;
    localparam int S_NUM      = 8;
    localparam int S_ID_WIDTH = 4;
    localparam int DATA_WIDTH = 32;
    localparam int M_ID_BITS  = 2;
    localparam int S_ID_BITS  = 4;

    logic                        clk = 1'b0;
    logic                        reset_n;
    logic                        cke;
    logic [M_NUM*S_ID_BITS-1:0]  s_id_to;
    logic [M_NUM-1:0]            s_last;
    logic [M_NUM*DATA_WIDTH-1:0] s_data;
    logic [M_NUM-1:0]            s_valid;
    logic [M_NUM-1:0]            s_ready;
    logic [S_NUM*M_ID_BITS-1:0]  m_id_from;
    logic [S_NUM-1:0]            m_last;
    logic [S_NUM*DATA_WIDTH-1:0] m_data;
    logic [S_NUM-1:0]            m_valid;
    logic [S_NUM-1:0]            m_ready;

    jelly_stream_crossbar_return #(
        .M_NUM(M_NUM), .M_ID_WIDTH(M_ID_WIDTH), .S_NUM(S_NUM),
        .S_ID_WIDTH(S_ID_WIDTH), .DATA_WIDTH(DATA_WIDTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cke(cke),
        .s_id_to(s_id_to), .s_last(s_last), .s_data(s_data),
        .s_valid(s_valid), .s_ready(s_ready),
        .m_id_from(m_id_from), .m_last(m_last), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [S_ID_BITS-1:0]  dest;
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
    } beat_t;

    beat_t q [M_NUM][$];

    int total = 0;
    int bad   = 0;

    // model state: owner of each output (-1 = none), last winner, output regs
    int   own [S_NUM], ptr [S_NUM], mid [S_NUM];
    bit   mv [S_NUM], ml [S_NUM];
    logic [DATA_WIDTH-1:0] md [S_NUM];
    int   n_own [S_NUM], n_ptr [S_NUM], n_mid [S_NUM];
    bit   n_mv [S_NUM], n_ml [S_NUM];
    logic [DATA_WIDTH-1:0] n_md [S_NUM];
    bit   exp_ready [M_NUM];
    int   out_hs [S_NUM];

    task automatic check(string tag, int idx, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
        end
    endtask

    function automatic int dest_of(int i);
        return int'(s_id_to[i*S_ID_BITS +: S_ID_BITS]);
    endfunction

    task automatic model_reset();
        for (int j = 0; j < S_NUM; j++) begin
            own[j] = -1; ptr[j] = M_NUM - 1; mv[j] = 0; ml[j] = 0; md[j] = '0; mid[j] = 0;
        end
    endtask

    task automatic model_eval();
        bit locked [M_NUM];
        for (int i = 0; i < M_NUM; i++) locked[i] = 0;
        for (int j = 0; j < S_NUM; j++) if (own[j] >= 0) locked[own[j]] = 1;
        for (int i = 0; i < M_NUM; i++) exp_ready[i] = cke && !locked[i] && (dest_of(i) >= S_NUM);
        for (int j = 0; j < S_NUM; j++) begin
            n_own[j] = own[j]; n_ptr[j] = ptr[j]; n_mv[j] = mv[j];
            n_ml[j] = ml[j]; n_md[j] = md[j]; n_mid[j] = mid[j];
            if (cke && (!mv[j] || m_ready[j])) begin
                int src;
                src = -1;
                if (own[j] >= 0) begin
                    exp_ready[own[j]] = 1;
                    if (s_valid[own[j]]) src = own[j];
                end else begin
                    for (int k = 1; k <= M_NUM; k++) begin
                        int c;
                        c = (ptr[j] + k) % M_NUM;
                        if (src < 0 && s_valid[c] && dest_of(c) == j && !locked[c]) src = c;
                    end
                    if (src >= 0) exp_ready[src] = 1;
                end
                if (src < 0) begin
                    n_mv[j] = 0;
                end else begin
                    n_mv[j] = 1;
                    n_md[j] = s_data[src*DATA_WIDTH +: DATA_WIDTH];
                    n_ml[j] = s_last[src];
                    n_mid[j] = src;
                    if (own[j] < 0) begin
                        n_ptr[j] = src;
                        n_own[j] = s_last[src] ? -1 : src;
                    end else if (s_last[src]) begin
                        n_own[j] = -1;
                    end
                end
            end
        end
    endtask

    task automatic model_commit();
        for (int j = 0; j < S_NUM; j++) begin
            own[j] = n_own[j]; ptr[j] = n_ptr[j]; mv[j] = n_mv[j];
            ml[j] = n_ml[j]; md[j] = n_md[j]; mid[j] = n_mid[j];
        end
    endtask

    task automatic check_outputs();
        for (int j = 0; j < S_NUM; j++) begin
            check("m_valid", j, m_valid[j], mv[j]);
            check("m_last", j, m_last[j], ml[j]);
            check("m_data", j, m_data[j*DATA_WIDTH +: DATA_WIDTH], md[j]);
            check("m_id_from", j, m_id_from[j*M_ID_BITS +: M_ID_BITS], mid[j]);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < M_NUM; i++) begin
            if (q[i].size() > 0) begin
                s_valid[i] = 1'b1;
                s_id_to[i*S_ID_BITS +: S_ID_BITS] = q[i][0].dest;
                s_data[i*DATA_WIDTH +: DATA_WIDTH] = q[i][0].data;
                s_last[i] = q[i][0].last;
            end else begin
                s_valid[i] = 1'b0;
                s_id_to[i*S_ID_BITS +: S_ID_BITS] = S_ID_BITS'($urandom_range(0, 7));
                s_data[i*DATA_WIDTH +: DATA_WIDTH] = $urandom;
                s_last[i] = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        model_eval();
        for (int i = 0; i < M_NUM; i++) check("s_ready", i, s_ready[i], exp_ready[i]);
        for (int j = 0; j < S_NUM; j++) if (m_valid[j] && m_ready[j]) out_hs[j]++;
        @(posedge clk);
        #1;
        model_commit();
        check_outputs();
        for (int i = 0; i < M_NUM; i++) if (s_valid[i] && exp_ready[i]) void'(q[i].pop_front());
        drive();
    endtask

    function automatic bit idle();
        bit r;
        r = 1;
        for (int i = 0; i < M_NUM; i++) if (q[i].size() != 0) r = 0;
        for (int j = 0; j < S_NUM; j++) if (mv[j] || own[j] >= 0) r = 0;
        return r;
    endfunction

    function automatic beat_t mk(int dest, logic [31:0] data, bit last);
        beat_t b;
        b.dest = S_ID_BITS'(dest); b.data = data; b.last = last;
        return b;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int ids [$];
        int cnt;
        reset_n = 1'b0; cke = 1'b0; s_valid = '0; s_id_to = '0;
        s_data = '0; s_last = '0; m_ready = '0;
        for (int j = 0; j < S_NUM; j++) out_hs[j] = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        check("rst_s_ready", 0, s_ready, 0);
        reset_n = 1'b1; cke = 1'b1; m_ready = '1;

        // 1: three-beat packet from input 1 to output 5
        q[1].push_back(mk(5, 32'h11, 0));
        q[1].push_back(mk(5, 32'h22, 0));
        q[1].push_back(mk(5, 32'h33, 1));
        drive();
        cycle();
        check("t1_valid", 1, m_valid[5], 1); check("t1_data", 1, m_data[5*32 +: 32], 32'h11);
        check("t1_id", 1, m_id_from[5*2 +: 2], 1); check("t1_last", 1, m_last[5], 0);
        cycle();
        check("t1_valid", 2, m_valid[5], 1); check("t1_data", 2, m_data[5*32 +: 32], 32'h22);
        check("t1_last", 2, m_last[5], 0);
        cycle();
        check("t1_valid", 3, m_valid[5], 1); check("t1_data", 3, m_data[5*32 +: 32], 32'h33);
        check("t1_last", 3, m_last[5], 1);
        cycle();
        check("t1_valid", 4, m_valid[5], 0);

        // 2: three inputs, two 2-beat packets each, to output 3
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 3; i++)
                for (int b = 0; b < 2; b++)
                    q[i].push_back(mk(3, 32'h2000 + i*256 + p*16 + b, b == 1));
        drive();
        for (int c = 0; c < 40 && !idle(); c++) begin
            cycle();
            if (m_valid[3]) ids.push_back(int'(m_id_from[3*2 +: 2]));
        end
        check("t2_drain", 0, idle(), 1);
        check("t2_count", 0, ids.size(), 12);
        for (int k = 0; k < 12 && k < ids.size(); k++) check("t2_order", k, ids[k], (k/2) % 3);

        // 3: destination changes mid-packet are ignored while locked
        q[2].push_back(mk(0, 32'h31, 0));
        q[2].push_back(mk(4, 32'h32, 0));
        q[2].push_back(mk(4, 32'h33, 1));
        drive();
        cnt = 0;
        for (int c = 0; c < 20 && !idle(); c++) begin
            cycle();
            check("t3_out4_idle", c, m_valid[4], 0);
            if (m_valid[0]) cnt++;
        end
        check("t3_drain", 0, idle(), 1);
        check("t3_out0_beats", 0, cnt, 3);

        // 4: back-pressure on output 6
        for (int b = 0; b < 4; b++) q[3].push_back(mk(6, 32'h40 + b, b == 3));
        drive();
        out_hs[6] = 0;
        for (int c = 0; c < 20 && !idle(); c++) begin
            m_ready[6] = (c == 1 || c == 2) ? 1'b0 : 1'b1;
            cycle();
        end
        m_ready = '1;
        check("t4_drain", 0, idle(), 1);
        check("t4_beats", 0, out_hs[6], 4);

        // 5: out-of-range destination alongside a normal packet
        q[0].push_back(mk(9, 32'h51, 0));
        q[0].push_back(mk(9, 32'h52, 1));
        q[1].push_back(mk(2, 32'h53, 0));
        q[1].push_back(mk(2, 32'h54, 1));
        drive();
        #1;
        check("t5_oor_ready", 0, s_ready[0], 1);
        cnt = 0;
        for (int c = 0; c < 20 && !idle(); c++) begin
            cycle();
            check("t5_stray", c, m_valid & 8'hFB, 8'h00);
            if (m_valid[2]) cnt++;
        end
        check("t5_drain", 0, idle(), 1);
        check("t5_out2_beats", 0, cnt, 2);

        // 6: asynchronous reset mid-packet, then clock-enable freeze
        for (int b = 0; b < 4; b++) q[3].push_back(mk(1, 32'h60 + b, b == 3));
        drive();
        cycle();
        cycle();
        reset_n = 1'b0;
        #1;
        check("t6_async", 0, m_valid, 8'h00);
        model_reset();
        #1;
        reset_n = 1'b1;
        q[0].push_back(mk(1, 32'h6A, 1));
        drive();
        cycle();
        check("t6_head", 0, m_id_from[1*2 +: 2], 0);
        cke = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            check("t6_freeze", c, m_valid, 8'h02);
        end
        cke = 1'b1;
        cycle();
        check("t6_next", 0, m_id_from[1*2 +: 2], 3);
        for (int c = 0; c < 20 && !idle(); c++) cycle();
        check("t6_drain", 0, idle(), 1);

        // random traffic
        for (int i = 0; i < M_NUM; i++) begin
            for (int p = 0; p < 20; p++) begin
                int len, d;
                len = $urandom_range(1, 4);
                d = ($urandom_range(0, 9) == 0) ? 9 : $urandom_range(0, 7);
                for (int b = 0; b < len; b++) begin
                    int db;
                    db = (b > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : d;
                    q[i].push_back(mk(db, $urandom, b == len - 1));
                end
            end
        end
        drive();
        for (int c = 0; c < 3000 && !idle(); c++) begin
            for (int j = 0; j < S_NUM; j++) m_ready[j] = ($urandom_range(0, 3) != 0);
            cke = ($urandom_range(0, 9) != 0);
            cycle();
        end
        check("rand_drain", 0, idle(), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
